// File: rtl/dot_product_feeder.sv
// Streams LEN operand pairs into a downstream accumulator as registered products,
// clearing it first and pulsing done once the final term has been summed.
module dot_product_feeder #(
    parameter int LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic       in_ready,
    output logic       acc_clear,
    output logic [7:0] acc_in,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [3:0] LastCnt = 4'(LEN);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] acc_in_q, acc_in_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            acc_in_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_in_q <= acc_in_d;
        end
    end

    // acc_in_d defaults to 0 so every non-accepting cycle contributes nothing;
    // the DRAIN cycle naturally shows the product registered on the last accept.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_in_d  = 8'd0;
        in_ready  = 1'b0;
        acc_clear = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                acc_clear = 1'b1;
                cnt_d     = 4'd0;
                state_d   = S_FEED;
            end
            S_FEED: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_in_d = {4'd0, a_in} * {4'd0, b_in};
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == LastCnt) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign acc_in = acc_in_q;

endmodule
